// File: rtl/bali_pkg.sv
// Shared definitions for the bali bytecode sequencer: word widths, the
// supported JVM opcodes, FSM state encoding and the opcode decoder.
package bali_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;

  localparam logic [7:0] NOP       = 8'h00;
  localparam logic [7:0] ICONST_M1 = 8'h02;
  localparam logic [7:0] ICONST_0  = 8'h03;
  localparam logic [7:0] ICONST_1  = 8'h04;
  localparam logic [7:0] ICONST_2  = 8'h05;
  localparam logic [7:0] ICONST_3  = 8'h06;
  localparam logic [7:0] ICONST_4  = 8'h07;
  localparam logic [7:0] ICONST_5  = 8'h08;
  localparam logic [7:0] BIPUSH    = 8'h10;
  localparam logic [7:0] SIPUSH    = 8'h11;
  localparam logic [7:0] LDC       = 8'h12;
  localparam logic [7:0] ILOAD     = 8'h15;
  localparam logic [7:0] ILOAD_0   = 8'h1a;
  localparam logic [7:0] ILOAD_1   = 8'h1b;
  localparam logic [7:0] ILOAD_2   = 8'h1c;
  localparam logic [7:0] ILOAD_3   = 8'h1d;
  localparam logic [7:0] ISTORE    = 8'h36;
  localparam logic [7:0] ISTORE_0  = 8'h3b;
  localparam logic [7:0] ISTORE_1  = 8'h3c;
  localparam logic [7:0] ISTORE_2  = 8'h3d;
  localparam logic [7:0] ISTORE_3  = 8'h3e;
  localparam logic [7:0] IADD      = 8'h60;
  localparam logic [7:0] ISUB      = 8'h64;
  localparam logic [7:0] GOTO      = 8'ha7;

  typedef enum logic [3:0] {
    IDLE, POP_A, WAIT_A, POP_B, WAIT_B, EXEC,
    LVA_REQ, LVA_WAIT, PUSH, WAIT_PUSH, DONE
  } state_t;

  // Execution path an opcode takes through the FSM
  typedef enum logic [2:0] {
    PATH_NONE,   // straight to DONE (nop, ldc, goto, unknown)
    PATH_PUSH,   // push an immediate
    PATH_LOAD,   // LVA read, then push
    PATH_STORE,  // pop, then LVA write
    PATH_ALU     // pop b, pop a, push a op b
  } path_t;

  typedef struct packed {
    path_t       path;
    logic [15:0] offset;  // PC increment reported with op_done
    logic [15:0] imm;     // immediate, sign-extended to DATA_W on push
    logic [7:0]  idx;     // local variable slot
    logic        sub;     // ALU subtracts instead of adds
    logic        ldc;     // pulse ldconst on completion
  } decode_t;

  function automatic decode_t decode(input logic [7:0] op,
                                     input logic [7:0] a1,
                                     input logic [7:0] a2);
    decode_t    d;
    logic [7:0] k;
    d.path   = PATH_NONE;
    d.offset = 16'd1;
    d.imm    = '0;
    d.idx    = '0;
    d.sub    = 1'b0;
    d.ldc    = 1'b0;
    // iconst_m1..iconst_5 push op-3; 8-bit wrap gives 0xFF for -1
    k = op - ICONST_0;
    case (op) inside
      NOP: ;
      [ICONST_M1:ICONST_5]: begin
        d.path = PATH_PUSH;
        d.imm  = {{8{k[7]}}, k};
      end
      BIPUSH: begin
        d.path   = PATH_PUSH;
        d.imm    = {{8{a1[7]}}, a1};
        d.offset = 16'd2;
      end
      SIPUSH: begin
        d.path   = PATH_PUSH;
        d.imm    = {a1, a2};
        d.offset = 16'd3;
      end
      LDC: begin
        d.ldc    = 1'b1;
        d.offset = 16'd2;
      end
      ILOAD: begin
        d.path   = PATH_LOAD;
        d.idx    = a1;
        d.offset = 16'd2;
      end
      [ILOAD_0:ILOAD_3]: begin
        d.path = PATH_LOAD;
        d.idx  = op - ILOAD_0;
      end
      ISTORE: begin
        d.path   = PATH_STORE;
        d.idx    = a1;
        d.offset = 16'd2;
      end
      [ISTORE_0:ISTORE_3]: begin
        d.path = PATH_STORE;
        d.idx  = op - ISTORE_0;
      end
      IADD: d.path = PATH_ALU;
      ISUB: begin
        d.path = PATH_ALU;
        d.sub  = 1'b1;
      end
      GOTO: d.offset = {a1, a2};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bytecode_control.sv
// Single-opcode sequencer for the bali Java core. Decodes the opcode in
// IDLE, then drives the eval-stack and LVA units through one-cycle
// trigger / done handshakes and reports completion with a PC offset.
module bytecode_control #(
  parameter int DATA_W = bali_pkg::DATA_W,
  parameter int IDX_W  = bali_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        op_code,
  input  logic [7:0]        arg1,
  input  logic [7:0]        arg2,
  input  logic              lvadone,
  input  logic [DATA_W-1:0] lvaread,
  output logic [DATA_W-1:0] lvawrite,
  output logic [IDX_W-1:0]  lvaindex,
  output logic              lvaop,
  output logic              lvatrigger,
  output logic              lvamove,
  output logic [IDX_W-1:0]  lvamoveindex,
  input  logic              lvamovedone,
  output logic              evalpush,
  output logic              evaltrigger,
  input  logic [DATA_W-1:0] evalread,
  output logic [DATA_W-1:0] evalwrite,
  input  logic              evaldone,
  output logic              ldconst,
  output logic [15:0]       offset,
  output logic              op_done
);
  import bali_pkg::*;

  state_t            state;
  decode_t           dec;
  path_t             path_reg;
  logic [15:0]       offset_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              sub_reg;
  logic [DATA_W-1:0] operand_b_reg;

  // Frame-move ports are reserved: requests held low, done input unused
  logic unused_movedone;
  assign unused_movedone = lvamovedone;
  assign lvamove         = 1'b0;
  assign lvamoveindex    = '0;

  assign dec = decode(op_code, arg1, arg2);

  // Sequencer: all handshake outputs are registered; every request state
  // lasts exactly one cycle so triggers are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      path_reg      <= PATH_NONE;
      offset_reg    <= '0;
      idx_reg       <= '0;
      sub_reg       <= 1'b0;
      operand_b_reg <= '0;
      lvawrite      <= '0;
      lvaindex      <= '0;
      lvaop         <= 1'b0;
      lvatrigger    <= 1'b0;
      evalpush      <= 1'b0;
      evaltrigger   <= 1'b0;
      evalwrite     <= '0;
      ldconst       <= 1'b0;
      offset        <= '0;
      op_done       <= 1'b0;
    end else begin
      evaltrigger <= 1'b0;
      lvatrigger  <= 1'b0;
      op_done     <= 1'b0;
      ldconst     <= 1'b0;
      case (state)
        IDLE: begin
          path_reg   <= dec.path;
          offset_reg <= dec.offset;
          idx_reg    <= IDX_W'(dec.idx);
          sub_reg    <= dec.sub;
          case (dec.path)
            PATH_PUSH: begin
              evalwrite   <= DATA_W'($signed(dec.imm));
              evalpush    <= 1'b1;
              evaltrigger <= 1'b1;
              state       <= PUSH;
            end
            PATH_LOAD: begin
              lvaindex   <= IDX_W'(dec.idx);
              lvaop      <= 1'b0;
              lvatrigger <= 1'b1;
              state      <= LVA_REQ;
            end
            PATH_STORE, PATH_ALU: begin
              evalpush    <= 1'b0;
              evaltrigger <= 1'b1;
              state       <= POP_A;
            end
            default: begin
              op_done <= 1'b1;
              offset  <= dec.offset;
              ldconst <= dec.ldc;
              state   <= DONE;
            end
          endcase
        end
        POP_A: state <= WAIT_A;
        WAIT_A: begin
          if (evaldone) begin
            if (path_reg == PATH_STORE) begin
              lvaindex   <= idx_reg;
              lvaop      <= 1'b1;
              lvawrite   <= evalread;
              lvatrigger <= 1'b1;
              state      <= LVA_REQ;
            end else begin
              // first pop is the right-hand operand b
              operand_b_reg <= evalread;
              evalpush      <= 1'b0;
              evaltrigger   <= 1'b1;
              state         <= POP_B;
            end
          end
        end
        POP_B: state <= WAIT_B;
        WAIT_B: begin
          if (evaldone) begin
            evalwrite   <= sub_reg ? (evalread - operand_b_reg)
                                   : (evalread + operand_b_reg);
            evalpush    <= 1'b1;
            evaltrigger <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: state <= WAIT_PUSH;
        LVA_REQ: state <= LVA_WAIT;
        LVA_WAIT: begin
          if (lvadone) begin
            if (lvaop) begin
              op_done <= 1'b1;
              offset  <= offset_reg;
              state   <= DONE;
            end else begin
              evalwrite   <= lvaread;
              evalpush    <= 1'b1;
              evaltrigger <= 1'b1;
              state       <= PUSH;
            end
          end
        end
        PUSH: state <= WAIT_PUSH;
        WAIT_PUSH: begin
          if (evaldone) begin
            op_done <= 1'b1;
            offset  <= offset_reg;
            state   <= DONE;
          end
        end
        DONE: begin
          offset <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_control.sv
// Directed bench for bytecode_control: responders emulate the eval stack and
// LVA, an instruction-level model predicts every request and completion.
module tb_bytecode_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  op_code, arg1, arg2;
  logic        lvadone, lvamovedone, evaldone;
  logic [31:0] lvaread, lvawrite, evalread, evalwrite;
  logic [7:0]  lvaindex, lvamoveindex;
  logic        lvaop, lvatrigger, lvamove, evalpush, evaltrigger;
  logic        ldconst, op_done;
  logic [15:0] offset;

  always #5 clk = ~clk;

  bytecode_control #(.DATA_W(32), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .arg1(arg1), .arg2(arg2),
    .lvadone(lvadone), .lvaread(lvaread), .lvawrite(lvawrite),
    .lvaindex(lvaindex), .lvaop(lvaop), .lvatrigger(lvatrigger),
    .lvamove(lvamove), .lvamoveindex(lvamoveindex), .lvamovedone(lvamovedone),
    .evalpush(evalpush), .evaltrigger(evaltrigger), .evalread(evalread),
    .evalwrite(evalwrite), .evaldone(evaldone), .ldconst(ldconst),
    .offset(offset), .op_done(op_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  op, a1, a2;
    int          stall;    // extra cycles before the first eval done
    int          lat;      // IDLE..op_done inclusive, 0 = not checked
    logic [31:0] lit;      // hand-computed pushed / stored value
    bit          has_lit;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [7:0] op, a1, a2, input int stall, lat,
                     input bit has_lit, input logic [31:0] lit);
    vec_t v;
    v.op = op; v.a1 = a1; v.a2 = a2; v.stall = stall; v.lat = lat;
    v.has_lit = has_lit; v.lit = lit;
    vecs.push_back(v);
  endtask

  // ---------------- responders ----------------
  logic [31:0] dut_stack[$];
  logic [31:0] lva_mem[256];
  int          stall_next = 0;

  initial begin : eval_responder
    int          d;
    logic        p;
    logic [31:0] w;
    evaldone = 1'b0;
    evalread = '0;
    forever begin
      @(negedge clk);
      evaldone = 1'b0;
      if (rst_n && evaltrigger) begin
        d = stall_next;
        stall_next = 0;
        p = evalpush;
        w = evalwrite;
        repeat (d) @(negedge clk);
        @(negedge clk);
        if (p) dut_stack.push_back(w);
        else if (dut_stack.size() > 0) evalread = dut_stack.pop_back();
        else evalread = '0;
        evaldone = 1'b1;
      end
    end
  end

  initial begin : lva_responder
    logic        wr;
    logic [7:0]  ix;
    logic [31:0] w;
    lvadone = 1'b0;
    lvaread = '0;
    forever begin
      @(negedge clk);
      lvadone = 1'b0;
      if (rst_n && lvatrigger) begin
        wr = lvaop;
        ix = lvaindex;
        w  = lvawrite;
        @(negedge clk);
        if (wr) lva_mem[ix] = w;
        else lvaread = lva_mem[ix];
        lvadone = 1'b1;
      end
    end
  end

  // ---------------- instruction-level model ----------------
  logic [31:0] model_stack[$];
  logic [31:0] model_lva[256];
  int          exp_pops, exp_lva, exp_lat;
  bit          exp_push, exp_ldc;
  logic [31:0] exp_push_val, exp_lva_wdata;
  logic [7:0]  exp_idx;
  logic [15:0] exp_off;

  function automatic logic [31:0] mpop();
    if (model_stack.size() == 0) return 32'h0;
    return model_stack.pop_back();
  endfunction

  // Present vector k to the DUT and predict what it must do
  task automatic load(input int k);
    vec_t        v;
    logic [31:0] a, b;
    int          op;
    v  = vecs[k];
    op = int'(v.op);
    op_code = v.op; arg1 = v.a1; arg2 = v.a2;
    stall_next = v.stall;
    exp_lat = v.lat;
    exp_pops = 0; exp_push = 0; exp_lva = 0; exp_ldc = 0;
    exp_off = 16'd1; exp_idx = '0; exp_push_val = '0; exp_lva_wdata = '0;
    if (op >= 2 && op <= 8) begin
      exp_push = 1; exp_push_val = op - 3;
    end else if (op == 'h10) begin
      exp_push = 1; exp_push_val = int'($signed(v.a1)); exp_off = 2;
    end else if (op == 'h11) begin
      exp_push = 1; exp_push_val = int'($signed({v.a1, v.a2})); exp_off = 3;
    end else if (op == 'h12) begin
      exp_ldc = 1; exp_off = 2;
    end else if (op == 'h15 || (op >= 'h1a && op <= 'h1d)) begin
      exp_lva = 1;
      exp_idx = (op == 'h15) ? v.a1 : 8'(op - 'h1a);
      if (op == 'h15) exp_off = 2;
      exp_push = 1; exp_push_val = model_lva[exp_idx];
    end else if (op == 'h36 || (op >= 'h3b && op <= 'h3e)) begin
      exp_pops = 1; exp_lva = 2;
      exp_idx = (op == 'h36) ? v.a1 : 8'(op - 'h3b);
      if (op == 'h36) exp_off = 2;
      exp_lva_wdata = mpop();
      model_lva[exp_idx] = exp_lva_wdata;
    end else if (op == 'h60 || op == 'h64) begin
      exp_pops = 2; exp_push = 1;
      b = mpop();
      a = mpop();
      exp_push_val = (op == 'h60) ? a + b : a - b;
    end else if (op == 'ha7) begin
      exp_off = {v.a1, v.a2};
    end
    if (exp_push) model_stack.push_back(exp_push_val);
    if (v.has_lit)
      check($sformatf("model_lit_op%02h", v.op), (exp_lva == 2) ? exp_lva_wdata : exp_push_val, v.lit);
  endtask

  // ---------------- main: drive + compare ----------------
  initial begin : main
    int  idx, cyc, ev_n, lv_n;
    bit  abort, got;
    for (int i = 0; i < 256; i++) begin
      lva_mem[i] = '0;
      model_lva[i] = '0;
    end
    lva_mem[2] = 32'h1234;        model_lva[2] = 32'h1234;
    lva_mem[0] = 32'hDEADBEEF;    model_lva[0] = 32'hDEADBEEF;

    //    op     a1     a2   stall lat lit? lit
    add(8'h02, 8'h00, 8'h00, 0, 0,  1, 32'hFFFFFFFF);
    add(8'h05, 8'h00, 8'h00, 0, 4,  1, 32'h2);
    add(8'h05, 8'h00, 8'h00, 0, 4,  1, 32'h2);
    add(8'h60, 8'h00, 8'h00, 0, 8,  1, 32'h4);
    add(8'h60, 8'h00, 8'h00, 0, 8,  1, 32'h3);
    add(8'h00, 8'h00, 8'h00, 0, 2,  0, 32'h0);
    add(8'h1c, 8'h00, 8'h00, 0, 6,  1, 32'h1234);
    add(8'h10, 8'h09, 8'h00, 0, 4,  1, 32'h9);
    add(8'h36, 8'h07, 8'h00, 0, 6,  1, 32'h9);
    add(8'ha7, 8'hFF, 8'hFA, 0, 2,  0, 32'h0);
    add(8'h12, 8'h05, 8'h00, 0, 2,  0, 32'h0);
    add(8'h11, 8'h80, 8'h01, 0, 4,  1, 32'hFFFF8001);
    add(8'h64, 8'h00, 8'h00, 10, 18, 1, 32'h00009233);
    add(8'h1a, 8'h00, 8'h00, 0, 6,  1, 32'hDEADBEEF);
    add(8'h3b, 8'h00, 8'h00, 0, 6,  1, 32'hDEADBEEF);
    add(8'h15, 8'h07, 8'h00, 0, 6,  1, 32'h9);
    add(8'hFF, 8'h00, 8'h00, 0, 2,  0, 32'h0);
    add(8'h08, 8'h00, 8'h00, 0, 4,  1, 32'h5);
    add(8'h60, 8'h00, 8'h00, 0, 8,  1, 32'hE);

    // reset held with a push opcode present: everything stays quiet
    rst_n = 1'b0; lvamovedone = 1'b0;
    op_code = 8'h02; arg1 = '0; arg2 = '0;
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs", {lvawrite, lvaindex, lvaop, lvatrigger, lvamove, lvamoveindex,
             evalpush, evaltrigger, evalwrite, ldconst, offset, op_done}, 128'h0);
    end
    load(0);
    rst_n = 1'b1;

    idx = 0; cyc = 0; ev_n = 0; lv_n = 0; abort = 0;
    while (idx < vecs.size() && !abort) begin
      @(negedge clk);
      cyc++;
      if (evaltrigger) begin
        if (ev_n < exp_pops) begin
          check($sformatf("pop_dir_v%0d", idx), evalpush, 1'b0);
        end else if (ev_n == exp_pops && exp_push) begin
          check($sformatf("push_dir_v%0d", idx), evalpush, 1'b1);
          check($sformatf("push_data_v%0d", idx), evalwrite, exp_push_val);
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_evaltrigger_v%0d actual=%0d triggers required=%0d", idx, ev_n + 1, exp_pops + int'(exp_push));
        end
        ev_n++;
      end
      if (lvatrigger) begin
        if (exp_lva == 0 || lv_n != 0) begin
          checks++; failures++;
          $display("FAIL unexpected_lvatrigger_v%0d actual=%0d triggers required=%0d", idx, lv_n + 1, (exp_lva != 0) ? 1 : 0);
        end else begin
          check($sformatf("lvaop_v%0d", idx), lvaop, (exp_lva == 2) ? 1'b1 : 1'b0);
          check($sformatf("lvaindex_v%0d", idx), lvaindex, exp_idx);
          if (exp_lva == 2) check($sformatf("lvawrite_v%0d", idx), lvawrite, exp_lva_wdata);
        end
        lv_n++;
      end
      if (ldconst && !op_done) begin
        checks++; failures++;
        $display("FAIL ldconst_without_done_v%0d actual=1 required=0", idx);
      end
      if (op_done) begin
        check($sformatf("offset_v%0d", idx), offset, exp_off);
        check($sformatf("ldconst_v%0d", idx), ldconst, exp_ldc);
        check($sformatf("eval_count_v%0d", idx), ev_n, exp_pops + int'(exp_push));
        check($sformatf("lva_count_v%0d", idx), lv_n, (exp_lva != 0) ? 1 : 0);
        if (exp_lat != 0) check($sformatf("latency_v%0d", idx), cyc, exp_lat);
        $display("op=%02h offset=%04h cycles=%0d eval_reqs=%0d lva_reqs=%0d", vecs[idx].op, offset, cyc, ev_n, lv_n);
        idx++;
        cyc = 0; ev_n = 0; lv_n = 0;
        if (idx < vecs.size()) load(idx);
      end
      if (cyc > 100) begin
        checks++; failures++;
        $display("FAIL timeout_v%0d actual=%0d cycles required=op_done", idx, cyc);
        abort = 1;
      end
    end

    // final stack and LVA contents against the model
    op_code = 8'h10; arg1 = 8'h33; arg2 = 8'h00;
    check("stack_depth", dut_stack.size(), model_stack.size());
    for (int i = 0; i < model_stack.size() && i < dut_stack.size(); i++)
      check($sformatf("stack_%0d", i), dut_stack[i], model_stack[i]);
    check("lva_7", lva_mem[7], model_lva[7]);
    check("lva_0", lva_mem[0], model_lva[0]);

    // abort a bipush right after its trigger
    got = 0;
    for (int t = 0; t < 6 && !got; t++) begin
      @(negedge clk);
      if (evaltrigger) got = 1;
    end
    check("midreset_trigger_seen", got, 1'b1);
    check("midreset_push_data", evalwrite, 32'h33);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {lvawrite, lvaindex, lvaop, lvatrigger, lvamove, lvamoveindex,
           evalpush, evaltrigger, evalwrite, ldconst, offset, op_done}, 128'h0);
    repeat (5) begin
      @(negedge clk);
      check("midreset_quiet", {evaltrigger, lvatrigger, op_done}, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
